// File: rtl/aexm_xctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aexm_xctl_pkg
// Purpose  : Shared encodings for the AEXM execute-stage sequencer.
//            - FSM state encoding (2-bit)
//            - rMXALU result-class constants
// Revision : 1.0 - initial release
// ============================================================================
package aexm_xctl_pkg;

    // Sequencer states
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_UNIT = 2'd1;
    localparam logic [1:0] c_MEM  = 2'd2;
    localparam logic [1:0] c_CMT  = 2'd3;

    // rMXALU result classes
    localparam logic [2:0] MX_ADD = 3'd0;
    localparam logic [2:0] MX_LOG = 3'd1;
    localparam logic [2:0] MX_SFT = 3'd2;
    localparam logic [2:0] MX_MOV = 3'd3;
    localparam logic [2:0] MX_MUL = 3'd4;
    localparam logic [2:0] MX_BSF = 3'd5;

endpackage : aexm_xctl_pkg
`default_nettype wire

// File: rtl/aexm_xctl_tmr.sv
`default_nettype none
// ============================================================================
// Module   : aexm_xctl_tmr
// Purpose  : 8-bit load/increment/decrement counter shared by the multi-cycle
//            unit wait and the data-access timeout, with terminal compares.
// Ports    : gclk       in  core clock
//            grst       in  synchronous active-low reset (count -> 0)
//            i_load     in  load i_loadVal (highest priority)
//            i_loadVal  in  8-bit load value
//            i_inc      in  increment
//            i_dec      in  decrement (lowest priority)
//            o_isOne    out count == 1
//            o_isTmo    out count == TMO_CMP
// Revision : 1.0 - initial release
// ============================================================================
module aexm_xctl_tmr #(
    parameter logic [7:0] TMO_CMP = 8'd253
) (
    input  logic       gclk,
    input  logic       grst,
    input  logic       i_load,
    input  logic [7:0] i_loadVal,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic       o_isOne,
    output logic       o_isTmo
);

    logic [7:0] r_cnt;

    always_ff @(posedge gclk) begin
        if (!grst) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_loadVal;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_isOne = (r_cnt == 8'd1);
    assign o_isTmo = (r_cnt == TMO_CMP);

endmodule : aexm_xctl_tmr
`default_nettype wire

// File: rtl/aexm_xctl.sv
`default_nettype none
// ============================================================================
// Module   : aexm_xctl
// Purpose  : Execute-stage sequencer. Decides per cycle when execute commits,
//            when MUL/BSF result registers capture, issues data-cache
//            strobes and freezes decode while an operation is in flight.
// Ports    : gclk    in  core clock
//            grst    in  synchronous active-low reset
//            op_vld  in  instruction present in execute
//            rMXALU  in  3-bit result class
//            op_mem  in  load/store
//            op_skip in  annulled instruction
//            dc_ack  in  data cache access complete
//            wb_hold in  downstream stall, forbids commit
//            x_en    out execute commit enable
//            u_cap   out MUL/BSF result capture enable (fSTALL)
//            dc_req  out one-cycle data access strobe
//            d_hold  out freeze decode/fetch
//            mem_err out sticky data-access timeout flag
//            busy    out sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module aexm_xctl #(
    parameter int MUL     = 0,
    parameter int BSF     = 0,
    parameter int MUL_LAT = 2,
    parameter int MEM_TMO = 255
) (
    input  logic       gclk,
    input  logic       grst,
    input  logic       op_vld,
    input  logic [2:0] rMXALU,
    input  logic       op_mem,
    input  logic       op_skip,
    input  logic       dc_ack,
    input  logic       wb_hold,
    output logic       x_en,
    output logic       u_cap,
    output logic       dc_req,
    output logic       d_hold,
    output logic       mem_err,
    output logic       busy
);

    import aexm_xctl_pkg::*;

    localparam bit         c_HAS_MUL  = (MUL != 0);
    localparam bit         c_HAS_BSF  = (BSF != 0);
    localparam bit         c_MUL_ONE  = (MUL_LAT == 1);
    localparam logic [7:0] c_MUL_LOAD = 8'(MUL_LAT - 1);
    // The counter is cleared at dc_req and first counts in the cycle after,
    // so it lags the cycle index by one. Comparing against MEM_TMO-2 makes
    // the timeout land in cycle MEM_TMO-1 counted from the dc_req cycle.
    localparam logic [7:0] c_TMO_CMP  = 8'(MEM_TMO - 2);

    logic [1:0] r_state;
    logic [1:0] w_stateNxt;
    logic       r_memErr;

    logic       w_xEn;
    logic       w_uCap;
    logic       w_dcReq;
    logic       w_setErr;
    logic       w_load;
    logic [7:0] w_loadVal;
    logic       w_inc;
    logic       w_dec;
    logic       w_cntOne;
    logic       w_cntTmo;
    logic       w_memDone;

    aexm_xctl_tmr #(
        .TMO_CMP (c_TMO_CMP)
    ) u_tmr (
        .gclk      (gclk),
        .grst      (grst),
        .i_load    (w_load),
        .i_loadVal (w_loadVal),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .o_isOne   (w_cntOne),
        .o_isTmo   (w_cntTmo)
    );

    // A timeout is handled exactly like an ack; an ack in the same cycle
    // wins so the error flag only marks genuine no-response aborts.
    assign w_memDone = dc_ack | w_cntTmo;

    always_comb begin
        w_stateNxt = r_state;
        w_xEn      = 1'b0;
        w_uCap     = 1'b0;
        w_dcReq    = 1'b0;
        w_setErr   = 1'b0;
        w_load     = 1'b0;
        w_loadVal  = 8'd0;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (op_vld && !wb_hold) begin
                    if (op_skip) begin
                        w_xEn = 1'b1;
                    end else if (op_mem) begin
                        w_dcReq    = 1'b1;
                        w_load     = 1'b1;
                        w_loadVal  = 8'd0;
                        w_stateNxt = c_MEM;
                    end else if (c_HAS_MUL && (rMXALU == MX_MUL)) begin
                        w_uCap     = 1'b1;
                        w_load     = 1'b1;
                        w_loadVal  = c_MUL_LOAD;
                        w_stateNxt = c_MUL_ONE ? c_CMT : c_UNIT;
                    end else if (c_HAS_BSF && (rMXALU == MX_BSF)) begin
                        w_uCap     = 1'b1;
                        w_stateNxt = c_CMT;
                    end else begin
                        w_xEn = 1'b1;
                    end
                end
            end
            c_UNIT: begin
                // Captures run to completion even under wb_hold; only the
                // commit in CMT waits for the downstream stall to clear.
                w_uCap = 1'b1;
                w_dec  = 1'b1;
                if (w_cntOne) begin
                    w_stateNxt = c_CMT;
                end
            end
            c_MEM: begin
                w_inc = 1'b1;
                if (w_memDone) begin
                    w_setErr = !dc_ack;
                    if (!wb_hold) begin
                        w_xEn      = 1'b1;
                        w_stateNxt = c_IDLE;
                    end else begin
                        w_stateNxt = c_CMT;
                    end
                end
            end
            c_CMT: begin
                if (!wb_hold) begin
                    w_xEn      = 1'b1;
                    w_stateNxt = c_IDLE;
                end
            end
            default: begin
                w_stateNxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (!grst) begin
            r_state  <= c_IDLE;
            r_memErr <= 1'b0;
        end else begin
            r_state <= w_stateNxt;
            if (w_setErr) begin
                r_memErr <= 1'b1;
            end
        end
    end

    // Commit is decided in the issue cycle, so outputs are combinational;
    // all are gated by reset so nothing escapes while grst is low.
    assign x_en    = grst & w_xEn;
    assign u_cap   = grst & w_uCap;
    assign dc_req  = grst & w_dcReq;
    assign d_hold  = grst & op_vld & !w_xEn;
    assign mem_err = grst & (r_memErr | w_setErr);
    assign busy    = grst & (r_state != c_IDLE);

endmodule : aexm_xctl
`default_nettype wire

// File: tb/tb_aexm_xctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aexm_xctl
// Purpose  : Directed self-checking bench for aexm_xctl (MUL=1, BSF=1,
//            MUL_LAT=3, MEM_TMO=8). Each step drives inputs after the
//            falling clock edge and checks the output vector
//            {x_en,u_cap,dc_req,d_hold,mem_err,busy} before the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aexm_xctl;

    logic       gclk;
    logic       grst;
    logic       op_vld;
    logic [2:0] rMXALU;
    logic       op_mem;
    logic       op_skip;
    logic       dc_ack;
    logic       wb_hold;
    logic       x_en;
    logic       u_cap;
    logic       dc_req;
    logic       d_hold;
    logic       mem_err;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    aexm_xctl #(
        .MUL     (1),
        .BSF     (1),
        .MUL_LAT (3),
        .MEM_TMO (8)
    ) dut (
        .gclk    (gclk),
        .grst    (grst),
        .op_vld  (op_vld),
        .rMXALU  (rMXALU),
        .op_mem  (op_mem),
        .op_skip (op_skip),
        .dc_ack  (dc_ack),
        .wb_hold (wb_hold),
        .x_en    (x_en),
        .u_cap   (u_cap),
        .dc_req  (dc_req),
        .d_hold  (d_hold),
        .mem_err (mem_err),
        .busy    (busy)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // One clock cycle: drive inputs, let them settle, compare outputs.
    task automatic step(input string tag, input logic rn, input logic vld,
                        input logic [2:0] alu, input logic mem, input logic skp,
                        input logic ack, input logic hld, input logic [5:0] exp);
        logic [5:0] obs;
        @(negedge gclk);
        grst    = rn;
        op_vld  = vld;
        rMXALU  = alu;
        op_mem  = mem;
        op_skip = skp;
        dc_ack  = ack;
        wb_hold = hld;
        #1;
        obs = {x_en, u_cap, dc_req, d_hold, mem_err, busy};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (x_en,u_cap,dc_req,d_hold,mem_err,busy)",
                   tag, obs, exp);
        end
    endtask

    initial begin
        grst = 1'b0; op_vld = 1'b0; rMXALU = 3'd0; op_mem = 1'b0;
        op_skip = 1'b0; dc_ack = 1'b0; wb_hold = 1'b0;

        //            tag            rn vld alu   mem skp ack hld  expected
        // Reset forces all outputs low even with an op presented
        step("rst_a",        0, 1, 3'd0, 0, 0, 0, 0, 6'b000000);
        step("rst_b",        0, 1, 3'd4, 1, 0, 1, 0, 6'b000000);
        step("idle",         1, 0, 3'd0, 0, 0, 0, 0, 6'b000000);

        // Single-cycle ops commit in the issue cycle
        step("add",          1, 1, 3'd0, 0, 0, 0, 0, 6'b100000);
        step("log",          1, 1, 3'd1, 0, 0, 0, 0, 6'b100000);
        step("mov",          1, 1, 3'd3, 0, 0, 0, 0, 6'b100000);

        // MUL, MUL_LAT=3: u_cap cycles 0-2, x_en cycle 3
        step("mul_c0",       1, 1, 3'd4, 0, 0, 0, 0, 6'b010100);
        step("mul_c1",       1, 1, 3'd4, 0, 0, 0, 0, 6'b010101);
        step("mul_c2",       1, 1, 3'd4, 0, 0, 0, 1, 6'b010101);
        step("mul_c3",       1, 1, 3'd4, 0, 0, 0, 0, 6'b100001);
        step("mul_done",     1, 0, 3'd0, 0, 0, 0, 0, 6'b000000);

        // Load with ack in cycle 4
        step("ld_c0",        1, 1, 3'd0, 1, 0, 0, 0, 6'b001100);
        step("ld_c1",        1, 1, 3'd0, 1, 0, 0, 0, 6'b000101);
        step("ld_c2",        1, 1, 3'd0, 1, 0, 0, 0, 6'b000101);
        step("ld_c3",        1, 1, 3'd0, 1, 0, 0, 0, 6'b000101);
        step("ld_c4_ack",    1, 1, 3'd0, 1, 0, 1, 0, 6'b100001);
        step("ld_ack_idle",  1, 0, 3'd0, 0, 0, 1, 0, 6'b000000);

        // BSF with wb_hold over cycles 1-3, commit in cycle 4
        step("bsf_c0",       1, 1, 3'd5, 0, 0, 0, 0, 6'b010100);
        step("bsf_c1_hold",  1, 1, 3'd5, 0, 0, 0, 1, 6'b000101);
        step("bsf_c2_hold",  1, 1, 3'd5, 0, 0, 0, 1, 6'b000101);
        step("bsf_c3_hold",  1, 1, 3'd5, 0, 0, 0, 1, 6'b000101);
        step("bsf_c4",       1, 1, 3'd5, 0, 0, 0, 0, 6'b100001);

        // wb_hold in IDLE blocks every start
        step("idle_hold_add",1, 1, 3'd0, 0, 0, 0, 1, 6'b000100);
        step("idle_hold_mem",1, 1, 3'd0, 1, 0, 0, 1, 6'b000100);
        step("idle_hold_mul",1, 1, 3'd4, 0, 0, 0, 1, 6'b000100);

        // Skipped MUL commits at once without capture
        step("skip_mul",     1, 1, 3'd4, 0, 1, 0, 0, 6'b100000);
        step("skip_after",   1, 0, 3'd0, 0, 0, 0, 0, 6'b000000);

        // Reset during UNIT aborts immediately
        step("rmul_c0",      1, 1, 3'd4, 0, 0, 0, 0, 6'b010100);
        step("rmul_c1",      1, 1, 3'd4, 0, 0, 0, 0, 6'b010101);
        step("rmul_rst",     0, 1, 3'd4, 0, 0, 0, 0, 6'b000000);
        step("rmul_post",    1, 0, 3'd0, 0, 0, 0, 0, 6'b000000);

        // Reset during MEM; ack after reset is ignored
        step("rld_c0",       1, 1, 3'd0, 1, 0, 0, 0, 6'b001100);
        step("rld_rst",      0, 1, 3'd0, 1, 0, 1, 0, 6'b000000);
        step("rld_post_ack", 1, 0, 3'd0, 0, 0, 1, 0, 6'b000000);

        // Earliest ack (cycle 1) under wb_hold goes through CMT
        step("hld_ld_c0",    1, 1, 3'd0, 1, 0, 0, 0, 6'b001100);
        step("hld_ld_c1",    1, 1, 3'd0, 1, 0, 1, 1, 6'b000101);
        step("hld_ld_c2",    1, 1, 3'd0, 1, 0, 0, 0, 6'b100001);

        // Ack coincides with timeout cycle: ack wins, no error
        step("race_c0",      1, 1, 3'd0, 1, 0, 0, 0, 6'b001100);
        for (int i = 1; i <= 6; i++)
            step("race_wait",1, 1, 3'd0, 1, 0, 0, 0, 6'b000101);
        step("race_c7_ack",  1, 1, 3'd0, 1, 0, 1, 0, 6'b100001);
        step("race_after",   1, 0, 3'd0, 0, 0, 0, 0, 6'b000000);

        // No ack, MEM_TMO=8: timeout and commit in cycle 7, error sticky
        step("tmo_c0",       1, 1, 3'd0, 1, 0, 0, 0, 6'b001100);
        for (int i = 1; i <= 6; i++)
            step("tmo_wait", 1, 1, 3'd0, 1, 0, 0, 0, 6'b000101);
        step("tmo_c7",       1, 1, 3'd0, 1, 0, 0, 0, 6'b100011);
        step("tmo_sticky",   1, 0, 3'd0, 0, 0, 0, 0, 6'b000010);
        step("tmo_sticky_add",1,1, 3'd2, 0, 0, 0, 0, 6'b100010);
        step("tmo_rst",      0, 0, 3'd0, 0, 0, 0, 0, 6'b000000);
        step("tmo_cleared",  1, 0, 3'd0, 0, 0, 0, 0, 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_aexm_xctl
`default_nettype wire

// File: doc/aexm_xctl.md
# aexm_xctl

Execute-stage sequencer for the AEXM core. It decides, cycle by cycle, when the execute unit commits (`x_en`) and when the multi-cycle multiplier/barrel-shifter result registers capture (`u_cap`, wired to the execute unit's `fSTALL`). It also issues data-cache access strobes for loads/stores, and freezes decode while a multi-cycle or memory operation is in flight. It sits between decode and the execute unit, alongside the data cache.

## Interface
Parameters:
- `MUL`, 0: multiplier present; when 0, class 4 is issued as single-cycle.
- `BSF`, 0: barrel shifter present; when 0, class 5 is issued as single-cycle.
- `MUL_LAT`, 2: multiplier capture cycles; legal range 1..15.
- `MEM_TMO`, 255: data-access timeout in cycles; legal range 2..255.

Ports:
- `gclk`  in  1  core clock.
- `grst`  in  1  reset; synchronous, active-low (`grst`=0 resets on the `gclk` edge).
- `op_vld`  in  1  instruction present in execute.
- `rMXALU`  in  3  result class: 0 ADD, 1 LOG, 2 SFT, 3 MOV, 4 MUL, 5 BSF.
- `op_mem`  in  1  instruction is a load/store.
- `op_skip`  in  1  instruction annulled (xSKIP).
- `dc_ack`  in  1  data cache completed the access.
- `wb_hold`  in  1  downstream stall; forbids commit.
- `x_en`  out  1  execute commit enable.
- `u_cap`  out  1  MUL/BSF result-register capture enable.
- `dc_req`  out  1  one-cycle data access strobe.
- `d_hold`  out  1  freeze decode/fetch.
- `mem_err`  out  1  sticky data-access timeout flag.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, UNIT, MEM, CMT. An 8-bit counter `cnt` is shared by UNIT and MEM.
- IDLE, when `op_vld` & !`wb_hold`:
  - `op_skip`: `x_en`=1, stay in IDLE. No `dc_req`, no `u_cap`.
  - `op_mem`: `dc_req`=1, `cnt`←0, go to MEM.
  - Class 4 with `MUL`=1: `u_cap`=1, `cnt`←`MUL_LAT`-1. Go to CMT if `MUL_LAT`=1, else to UNIT.
  - Class 5 with `BSF`=1: `u_cap`=1, go to CMT.
  - Any other class: `x_en`=1, stay in IDLE.
- IDLE with `wb_hold`=1: nothing starts; all outputs are 0 except `d_hold`.
- UNIT: `u_cap`=1 and `cnt` decrements every cycle, regardless of `wb_hold`. When `cnt`=1 (last capture), go to CMT.
- CMT: `x_en`=1 when `wb_hold`=0, then go to IDLE; otherwise stay in CMT.
- MEM: `cnt` increments each cycle.
  - `dc_ack` with `wb_hold`=0: `x_en`=1, go to IDLE.
  - `dc_ack` with `wb_hold`=1: go to CMT.
  - `cnt`=`MEM_TMO`-1 without `dc_ack`: set `mem_err`, then treat as an ack (abort commit).
  - `dc_ack` and timeout in the same cycle: the ack wins and `mem_err` is not set.
  - `dc_ack` is ignored outside MEM.
- `d_hold` = `op_vld` & !`x_en`. All outputs are forced to 0 while `grst`=0.
- `mem_err` is cleared only by reset.

## Timing
- Reset: state IDLE, `cnt`=0, `mem_err`=0. All outputs read 0 during and immediately after reset until `op_vld` rises.
- Single-cycle op: commits in the issue cycle (latency 0).
- MUL: `u_cap` is high for `MUL_LAT` consecutive cycles; `x_en` follows in the next cycle, for a total of `MUL_LAT`+1 cycles.
- BSF: one `u_cap` cycle, then `x_en`, for 2 cycles total.
- Memory: `dc_req` in cycle 0; the earliest `dc_ack` is honored in cycle 1, and `x_en` is asserted in the same cycle as the honored `dc_ack`.
- `x_en` and `u_cap` are never high in the same cycle. `x_en` is never high while `wb_hold`=1.
- Reset asserted mid-operation aborts immediately; a pending `dc_ack` after reset is ignored.

## Structure
- Package `aexm_xctl_pkg`: state encoding (IDLE=0, UNIT=1, MEM=2, CMT=3) and the `rMXALU` class constants `MX_ADD`..`MX_BSF`.
- One sub-module, `aexm_xctl_tmr`: 8-bit load/increment/decrement counter with terminal-count compares. The FSM stays in the top level.

## Test plan
- ADD with `op_vld`=1 and `wb_hold`=0 → `x_en`=1 in the same cycle; `d_hold`=0; `busy`=0.
- MUL with `MUL`=1, `MUL_LAT`=3 → `u_cap` high in cycles 0–2, `x_en` in cycle 3, `d_hold` high in cycles 0–2.
- Load with `dc_ack` at cycle 4 → `dc_req` at cycle 0 only; `x_en` at cycle 4; `busy` high in cycles 1–4.
- Load with no ack and `MEM_TMO`=8 → `mem_err` rises at cycle 7, `x_en` at cycle 7, and `mem_err` stays set until `grst`=0.
- BSF with `wb_hold` held high over cycles 1–3 → `u_cap` at cycle 0, CMT held, `x_en` at cycle 4.
- `grst`=0 during UNIT of a MUL → next cycle IDLE with all outputs 0. A skipped MUL (`op_skip`=1) → `x_en` in cycle 0, no `u_cap`.
